// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes used by the free list, RAT, ROB and PRF.
package rename_pkg;
   localparam int PHYS_REGS  = 64;
   localparam int ARCH_REGS  = 32;
   localparam int PHYS_TAG_W = 6;
   localparam int FL_DEPTH   = PHYS_REGS - ARCH_REGS;
   localparam int FL_IDX_W   = $clog2(FL_DEPTH);

   typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
   typedef logic [FL_IDX_W:0]     fl_ptr_t;
endpackage

// File: rtl/free_list_if.sv
// Rename-side handshake with the physical-register free list.
interface free_list_if;
   import rename_pkg::*;

   logic      alloc_req;
   logic      alloc_valid;
   phys_tag_t alloc_phys;
   logic      commit_valid;
   phys_tag_t commit_old_phys;
   logic      flush;
   fl_ptr_t   free_count;

   modport master (
      output alloc_req, commit_valid, commit_old_phys, flush,
      input  alloc_valid, alloc_phys, free_count
   );

   modport slave (
      input  alloc_req, commit_valid, commit_old_phys, flush,
      output alloc_valid, alloc_phys, free_count
   );
endinterface

// File: rtl/free_list_chk.sv
// Protocol checks for the free list; bound onto free_list instances.
module free_list_chk
   import rename_pkg::*;
(
   input logic      clk,
   input logic      rst,
   input logic      commit_valid,
   input phys_tag_t commit_old_phys,
   input fl_ptr_t   free_count,
   input fl_ptr_t   tail,
   input fl_ptr_t   retire_head
);

   fl_ptr_t retired_span;
   assign retired_span = tail - retire_head;

   a_no_tag0_return: assert property (@(posedge clk) disable iff (rst)
      commit_valid |-> (commit_old_phys != '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      commit_valid |-> (free_count != fl_ptr_t'(FL_DEPTH)));

   a_span_bound: assert property (@(posedge clk) disable iff (rst)
      retired_span <= fl_ptr_t'(FL_DEPTH));

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags with speculative head, retire head and tail.
module free_list
   import rename_pkg::*;
(
   input logic        clk,
   input logic        rst,
   free_list_if.slave fl
);

   phys_tag_t mem [FL_DEPTH];
   fl_ptr_t   spec_head;
   fl_ptr_t   retire_head;
   fl_ptr_t   tail;

   logic      alloc_req;
   logic      commit_valid;
   logic      flush;
   phys_tag_t commit_old_phys;
   fl_ptr_t   free_count;
   fl_ptr_t   retire_next;
   logic      alloc_take;

   assign alloc_req       = fl.alloc_req;
   assign commit_valid    = fl.commit_valid;
   assign flush           = fl.flush;
   assign commit_old_phys = fl.commit_old_phys;

   assign free_count  = tail - spec_head;
   assign alloc_take  = alloc_req && (free_count != '0) && !flush;
   assign retire_next = retire_head + fl_ptr_t'(commit_valid);

   assign fl.free_count  = free_count;
   assign fl.alloc_valid = (free_count != '0);
   assign fl.alloc_phys  = mem[spec_head[FL_IDX_W-1:0]];

   // Retired entries are never overwritten before spec_head passes them, so a
   // flush only has to rewind spec_head onto retire_head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            mem[i] <= phys_tag_t'(ARCH_REGS + i);
         end
         spec_head   <= '0;
         retire_head <= '0;
         tail        <= fl_ptr_t'(FL_DEPTH);
      end else begin
         if (commit_valid) begin
            mem[tail[FL_IDX_W-1:0]] <= commit_old_phys;
            tail                    <= tail + fl_ptr_t'(1);
         end
         retire_head <= retire_next;
         if (flush) begin
            spec_head <= retire_next;
         end else if (alloc_take) begin
            spec_head <= spec_head + fl_ptr_t'(1);
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Directed and random-recycle bench for free_list against a queue-based model.
bind free_list free_list_chk u_chk (
   .clk             (clk),
   .rst             (rst),
   .commit_valid    (commit_valid),
   .commit_old_phys (commit_old_phys),
   .free_count      (free_count),
   .tail            (tail),
   .retire_head     (retire_head)
);

module tb_free_list;
   import rename_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   free_list_if fl_if ();

   free_list dut (
      .clk (clk),
      .rst (rst),
      .fl  (fl_if)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrors = 0;
   bit started = 1'b0;

   // Model: ring holds tags from the oldest retired-side entry to the newest
   // pushed one; the first nspec of them are speculatively handed out.
   phys_tag_t ring [$];
   int        nspec;
   bit        live [PHYS_REGS];
   bit        track_live = 1'b0;

   phys_tag_t rat [ARCH_REGS];
   phys_tag_t rob [$];

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ring.delete();
      for (int i = 0; i < FL_DEPTH; i++) ring.push_back(phys_tag_t'(ARCH_REGS + i));
      nspec = 0;
   endtask

   int m_fc;
   bit m_taken;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         m_fc    = ring.size() - nspec;
         m_taken = fl_if.alloc_req && (m_fc > 0) && !fl_if.flush;
         if (m_taken) live[ring[nspec]] = 1'b1;
         if (fl_if.commit_valid) begin
            void'(ring.pop_front());
            ring.push_back(fl_if.commit_old_phys);
            live[fl_if.commit_old_phys] = 1'b0;
         end
         nspec = nspec + int'(m_taken) - int'(fl_if.commit_valid);
         if (fl_if.flush) nspec = 0;
      end
   end

   int c_fc;
   always @(negedge clk) begin
      if (started) begin
         c_fc = ring.size() - nspec;
         chk("free_count", int'(fl_if.free_count), c_fc);
         chk("alloc_valid", int'(fl_if.alloc_valid), int'(c_fc != 0));
         if (c_fc > 0) chk("alloc_phys", int'(fl_if.alloc_phys), int'(ring[nspec]));
         if (fl_if.alloc_valid && fl_if.alloc_req && !fl_if.flush) begin
            chk("issued_tag_nonzero", int'(fl_if.alloc_phys != '0), 1);
            if (track_live) chk("issued_tag_not_live", int'(live[fl_if.alloc_phys]), 0);
         end
      end
   end

   task automatic drive(input bit a, input bit c, input int old, input bit f);
      fl_if.alloc_req       = a;
      fl_if.commit_valid    = c;
      fl_if.commit_old_phys = phys_tag_t'(old);
      fl_if.flush           = f;
      @(posedge clk);
      #1;
      fl_if.alloc_req       = 1'b0;
      fl_if.commit_valid    = 1'b0;
      fl_if.commit_old_phys = '0;
      fl_if.flush           = 1'b0;
   endtask

   task automatic sync_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit a, c;
      int old, r;

      fl_if.alloc_req       = 1'b0;
      fl_if.commit_valid    = 1'b0;
      fl_if.commit_old_phys = '0;
      fl_if.flush           = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;

      // Reset state
      chk("rst_valid", int'(fl_if.alloc_valid), 1);
      chk("rst_phys", int'(fl_if.alloc_phys), 32);
      chk("rst_count", int'(fl_if.free_count), 32);

      // Drain: 32 tags in order, the 33rd request is ignored
      for (int i = 0; i < 33; i++) begin
         if (i < 32) chk("drain_tag", int'(fl_if.alloc_phys), 32 + i);
         drive(1'b1, 1'b0, 0, 1'b0);
      end
      chk("empty_count", int'(fl_if.free_count), 0);
      chk("empty_valid", int'(fl_if.alloc_valid), 0);

      // Recycle while empty: no allocation, the pushed tag shows next cycle
      drive(1'b1, 1'b1, 5, 1'b0);
      chk("recycle_valid", int'(fl_if.alloc_valid), 1);
      chk("recycle_phys", int'(fl_if.alloc_phys), 5);
      chk("recycle_count", int'(fl_if.free_count), 1);

      // Asynchronous reset in mid-cycle
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(fl_if.alloc_valid), 1);
      chk("async_rst_phys", int'(fl_if.alloc_phys), 32);
      chk("async_rst_count", int'(fl_if.free_count), 32);
      @(posedge clk);
      #1 rst = 1'b0;

      // Flush recovery
      for (int i = 0; i < 10; i++) begin
         chk("spec_tag", int'(fl_if.alloc_phys), 32 + i);
         drive(1'b1, 1'b0, 0, 1'b0);
      end
      for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, i, 1'b0);
      chk("pre_flush_count", int'(fl_if.free_count), 25);
      drive(1'b0, 1'b0, 0, 1'b1);
      chk("flush_count", int'(fl_if.free_count), 32);
      chk("flush_phys", int'(fl_if.alloc_phys), 35);
      for (int i = 0; i < 7; i++) begin
         chk("reissue_tag", int'(fl_if.alloc_phys), 35 + i);
         drive(1'b1, 1'b0, 0, 1'b0);
      end

      // Flush with same-cycle commit and alloc
      sync_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b1, 7, 1'b1);
      chk("flush_commit_count", int'(fl_if.free_count), 32);
      chk("flush_commit_phys", int'(fl_if.alloc_phys), 33);

      // Random rename/commit traffic with a tiny RAT and ROB
      sync_reset();
      for (int i = 0; i < PHYS_REGS; i++) live[i] = (i < ARCH_REGS);
      for (int i = 0; i < ARCH_REGS; i++) rat[i] = phys_tag_t'(i);
      rob.delete();
      track_live = 1'b1;
      for (int n = 0; n < 100; n++) begin
         c   = (rob.size() > 0) && ($urandom_range(0, 1) == 1);
         old = c ? int'(rob.pop_front()) : 0;
         a   = ((ring.size() - nspec) > 0) && ($urandom_range(0, 99) < 60);
         if (a) begin
            r = $urandom_range(1, ARCH_REGS - 1);
            rob.push_back(rat[r]);
            rat[r] = ring[nspec];
         end
         drive(a, c, old, 1'b0);
      end
      while (rob.size() > 0) drive(1'b0, 1'b1, int'(rob.pop_front()), 1'b0);
      chk("final_count", int'(fl_if.free_count), 32);
      track_live = 1'b0;

      @(negedge clk);
      started = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
